shared_reg_arbiter: RTL and testbench

- Round-robin arbiter and write sequencer for one shared WIDTH-bit storage register built from D flip-flops.
- Up to NUM_REQ requesters compete to load the register. The block grants one requester per write slot and performs the load.
- It exposes the stored value, grant vector, owner ID and a write counter.
- It sits between requester logic and the shared register, and replaces per-requester enable muxing.

---
 rtl/shared_reg_arbiter.sv | 139 +++++++++++++
 tb/tb_shared_reg_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for a single shared WIDTH-bit register.
// One requester is granted per two-cycle write slot; after it writes it gets the lowest priority.
module shared_reg_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] wdata,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     busy,
   output logic [WIDTH-1:0]         q,
   output logic [IDW-1:0]           owner,
   output logic [15:0]              wr_count
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t               state_q;
   logic [NUM_REQ-1:0]   gnt_q;
   logic                 busy_q;
   logic [WIDTH-1:0]     data_q;
   logic [IDW-1:0]       owner_q;
   logic [15:0]          cnt_q;
   logic [IDW-1:0]       ptr_q;
   logic [IDW-1:0]       win_q;

   logic                 found_s;
   logic [IDW-1:0]       win_s;
   logic [IDW:0]         cand_s;
   logic [WIDTH-1:0]     wsel_s;
   logic [IDW-1:0]       ptr_d;

   // Rotating search for the first active request starting at the priority pointer.
   always_comb begin
      found_s = 1'b0;
      win_s   = ptr_q;
      cand_s  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_s = {1'b0, ptr_q} + (IDW+1)'(i);
         if (cand_s >= (IDW+1)'(NUM_REQ)) begin
            cand_s = cand_s - (IDW+1)'(NUM_REQ);
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && req[cand_s[IDW-1:0]]) begin
            found_s = 1'b1;
            win_s   = cand_s[IDW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // Data of the latched winner only; other requesters' data never reaches the register.
   always_comb begin
      wsel_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDW'(i) == win_q) begin
            wsel_s = wdata[i*WIDTH +: WIDTH];
         end else begin
            wsel_s = wsel_s;
         end
      end
   end

   // Pointer following the winner, wrapping at NUM_REQ.
   always_comb begin
      if (win_q == IDW'(NUM_REQ-1)) begin
         ptr_d = '0;
      end else begin
         ptr_d = win_q + IDW'(1);
      end
   end

   // Two-state grant/write FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         data_q  <= '0;
         owner_q <= '0;
         cnt_q   <= 16'h0000;
         ptr_q   <= '0;
         win_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (en && found_s) begin
                  gnt_q   <= NUM_REQ'(1) << win_s;
                  win_q   <= win_s;
                  busy_q  <= 1'b1;
                  state_q <= GRANT;
               end else begin
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            GRANT: begin
               // A requester that dropped its request before the closing edge forfeits the slot.
               if (req[win_q]) begin
                  data_q  <= wsel_s;
                  owner_q <= win_q;
                  cnt_q   <= cnt_q + 16'd1;
                  ptr_q   <= ptr_d;
               end else begin
                  data_q  <= data_q;
                  owner_q <= owner_q;
                  cnt_q   <= cnt_q;
                  ptr_q   <= ptr_q;
               end
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt      = gnt_q;
   assign busy     = busy_q;
   assign q        = data_q;
   assign owner    = owner_q;
   assign wr_count = cnt_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter with a cycle-level reference model and per-cycle comparison.
module tb_shared_reg_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;
   localparam int IDW     = 2;

   logic                     clk;
   logic                     rst;
   logic                     en;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] wdata;
   logic [NUM_REQ-1:0]       gnt;
   logic                     busy;
   logic [WIDTH-1:0]         q;
   logic [IDW-1:0]           owner;
   logic [15:0]              wr_count;

   int n_chk  = 0;
   int n_fail = 0;

   shared_reg_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .wdata(wdata),
      .gnt(gnt), .busy(busy), .q(q), .owner(owner), .wr_count(wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: slot-level behaviour kept in plain integers.
   int         m_busy, m_win, m_ptr, m_owner, m_writes;
   int         m_gnt_idx;
   logic [7:0] m_q;
   int         cnt_bias = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy <= 0; m_win <= 0; m_ptr <= 0; m_owner <= 0;
         m_writes <= 0; m_q <= 8'h00; m_gnt_idx <= -1;
      end else if (m_busy == 0) begin
         if (en && req != 4'b0000) begin
            int w;
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
               if (w < 0 && req[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
            end
            m_win <= w; m_gnt_idx <= w; m_busy <= 1;
         end else begin
            m_gnt_idx <= -1;
         end
      end else begin
         if (req[m_win]) begin
            m_q      <= wdata[m_win*WIDTH +: WIDTH];
            m_owner  <= m_win;
            m_writes <= m_writes + 1;
            m_ptr    <= (m_win + 1) % NUM_REQ;
         end
         m_gnt_idx <= -1;
         m_busy    <= 0;
      end
   end

   // Per-cycle comparison against the model plus structural invariants.
   always @(negedge clk) begin
      logic [3:0]  e_gnt;
      logic [15:0] e_cnt;
      e_gnt = (m_gnt_idx < 0) ? 4'b0000 : (4'b0001 << m_gnt_idx);
      e_cnt = 16'(m_writes + cnt_bias);
      chk("model_gnt",   32'(gnt), 32'(e_gnt));
      chk("model_busy",  32'(busy), 32'(m_busy));
      chk("model_q",     32'(q), 32'(m_q));
      chk("model_owner", 32'(owner), 32'(m_owner));
      chk("model_cnt",   32'(wr_count), 32'(e_cnt));
      chk("inv_onehot",  32'($countones(gnt) <= 1), 32'(1));
      chk("inv_gnt_busy", 32'((gnt != 4'b0000) == busy), 32'(1));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; en = 1'b0; req = 4'b0000; wdata = '0;
      repeat (2) @(negedge clk);
      chk("reset_q", 32'(q), 32'h0);
      chk("reset_cnt", 32'(wr_count), 32'h0);
      rst = 1'b1;
      @(negedge clk);

      // Single requester 2
      en = 1'b1; req = 4'b0100; wdata[23:16] = 8'h3C;
      @(negedge clk);
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("single_q", 32'(q), 32'h3C);
      chk("single_owner", 32'(owner), 32'h2);
      chk("single_cnt", 32'(wr_count), 32'h1);
      chk("single_busy_done", 32'(busy), 32'h0);
      req = 4'b0000;

      // Load 0x5A then reset asynchronously mid-run
      req = 4'b0001; wdata[7:0] = 8'h5A;
      @(negedge clk);
      @(negedge clk);
      req = 4'b0000;
      chk("pre_reset_q", 32'(q), 32'h5A);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_q", 32'(q), 32'h0);
      chk("async_rst_cnt", 32'(wr_count), 32'h0);
      chk("async_rst_owner", 32'(owner), 32'h0);
      chk("async_rst_gnt", 32'(gnt), 32'h0);
      chk("async_rst_busy", 32'(busy), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_q", 32'(q), 32'h0);
      chk("post_rst_gnt", 32'(gnt), 32'h0);

      // Rotation with all requesters active
      wdata = {8'h13, 8'h12, 8'h11, 8'h10};
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rot_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
         @(negedge clk);
         chk("rot_q", 32'(q), 32'(8'h10 + (k % 4)));
      end
      req = 4'b0000;
      chk("rot_cnt", 32'(wr_count), 32'h5);

      // Abort: requester 1 drops its request during GRANT
      wdata[15:8] = 8'h77;
      req = 4'b0010;
      @(negedge clk);
      chk("abort_gnt", 32'(gnt), 32'h2);
      req = 4'b0000;
      @(negedge clk);
      chk("abort_q", 32'(q), 32'h10);
      chk("abort_owner", 32'(owner), 32'h0);
      chk("abort_cnt", 32'(wr_count), 32'h5);
      req = 4'b0011;
      @(negedge clk);
      chk("abort_regrant", 32'(gnt), 32'h2);
      @(negedge clk);
      chk("regrant_q", 32'(q), 32'h77);
      chk("regrant_owner", 32'(owner), 32'h1);
      chk("regrant_cnt", 32'(wr_count), 32'h6);
      req = 4'b0000;

      // Enable gating
      en = 1'b0; req = 4'b0001;
      repeat (10) begin
         @(negedge clk);
         chk("en_off_gnt", 32'(gnt), 32'h0);
      end
      en = 1'b1;
      @(negedge clk);
      chk("en_on_gnt", 32'(gnt), 32'h1);
      en = 1'b0;
      @(negedge clk);
      chk("en_drop_q", 32'(q), 32'h10);
      chk("en_drop_cnt", 32'(wr_count), 32'h7);
      repeat (4) begin
         @(negedge clk);
         chk("en_drop_nognt", 32'(gnt), 32'h0);
      end
      req = 4'b0000;

      // Counter wrap: preload 0xFFFF, then one more write
      #1 force dut.cnt_q = 16'hFFFF;
      cnt_bias = 16'hFFFF - 7;
      #1 release dut.cnt_q;
      @(negedge clk);
      chk("wrap_pre", 32'(wr_count), 32'hFFFF);
      en = 1'b1; req = 4'b0100; wdata[23:16] = 8'hAB;
      @(negedge clk);
      @(negedge clk);
      chk("wrap_cnt", 32'(wr_count), 32'h0);
      chk("wrap_q", 32'(q), 32'hAB);
      req = 4'b0000;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
